// File: rtl/sparse_pkg.sv
// sparse_pkg: shared types and helpers for the sparse event serializer.
//   scan_state_t - scanner FSM states (IDLE, SCAN)
//   beats_for    - number of link beats needed to carry a word
//   lowest_set   - index of the lowest set bit of a channel vector
// MAX_CH bounds the channel count that lowest_set can handle.
package sparse_pkg;

  localparam int MAX_CH = 256;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } scan_state_t;

  // Ceiling division: beats of link_w bits needed to cover word_w bits.
  function automatic int beats_for(input int word_w, input int link_w);
    return (word_w + link_w - 1) / link_w;
  endfunction

  // Returns the lowest set bit index, 0 for an all-zero vector.
  // Scans from the top so the last hit (the lowest index) wins.
  function automatic int lowest_set(input logic [MAX_CH-1:0] vec);
    int idx;
    idx = 0;
    for (int i = MAX_CH - 1; i >= 0; i--) begin
      if (vec[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/sparse_event_serializer_fifo.sv
// sparse_fifo: show-ahead synchronous FIFO for address words.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   push, push_data write one word (caller never pushes when full unless popping)
//   pop, pop_data   pop_data shows the head word; pop advances it
//   full, empty     status flags
// Pointers carry one extra wrap bit so full and empty are distinguishable
// without a separate counter.
module sparse_fifo #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W:0]   wr_ptr_reg;
  logic [PTR_W:0]   rd_ptr_reg;

  assign empty    = (wr_ptr_reg == rd_ptr_reg);
  assign full     = (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W]) &&
                    (wr_ptr_reg[PTR_W-1:0] == rd_ptr_reg[PTR_W-1:0]);
  assign pop_data = mem[rd_ptr_reg[PTR_W-1:0]];

  // Storage has no reset so it can map onto distributed/block RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg[PTR_W-1:0]] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

endmodule

// File: rtl/sparse_event_serializer.sv
// sparse_event_serializer: scans an N_CH-bit event frame for active
// channels (ascending index), queues one {last, addr} word per event in a
// FIFO, and streams each word over a LINK_W-bit valid/ready link, LSB beat
// first.
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   in_events, in_valid  event frame and its valid
//   in_ready             scanner idle, frame can be taken
//   out_data, out_valid  current link beat
//   out_ready            downstream accepts the beat
//   busy                 scan active, words queued, or a word in flight
// Build option: define SPARSE_SER_EMPTY_FRAME_EN to emit a {1, NULL_ADDR}
// word for an all-zero frame so the frame boundary is still visible.
module sparse_event_serializer
  import sparse_pkg::*;
#(
  parameter int N_CH   = 16,
  parameter int LINK_W = 4,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH-1:0]   in_events,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [LINK_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy
);

  localparam int ADDR_W = $clog2(N_CH + 1);
  localparam int WORD_W = ADDR_W + 1;
  localparam int BEATS  = beats_for(WORD_W, LINK_W);
  localparam int PAD_W  = BEATS * LINK_W;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [ADDR_W-1:0] NULL_ADDR = '1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  // ---------------- scanner ----------------
  scan_state_t       state_reg, state_next;
  logic [N_CH-1:0]   pending_reg, pending_next;
  logic [ADDR_W-1:0] lowest_idx;
  logic              last_one;
  logic              push;
  logic [WORD_W-1:0] push_word;
  logic              fifo_full, fifo_empty;
  logic              pop;
  logic [WORD_W-1:0] pop_word;

  assign in_ready   = (state_reg == IDLE);
  assign lowest_idx = ADDR_W'(lowest_set(MAX_CH'(pending_reg)));
  // Only one bit set: clearing the lowest leaves nothing.
  assign last_one   = ((pending_reg & (pending_reg - N_CH'(1))) == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      pending_reg <= '0;
    end else begin
      state_reg   <= state_next;
      pending_reg <= pending_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    pending_next = pending_reg;
    push         = 1'b0;
    push_word    = '0;
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          pending_next = in_events;
`ifdef SPARSE_SER_EMPTY_FRAME_EN
          state_next = SCAN;
`else
          if (|in_events) state_next = SCAN;
`endif
        end
      end
      SCAN: begin
        // A full FIFO stalls the scan with pending_reg held.
        if (!fifo_full) begin
          push = 1'b1;
          if (pending_reg == '0) begin
            // Only reachable for an empty frame: delimiter word.
            push_word  = {1'b1, NULL_ADDR};
            state_next = IDLE;
          end else begin
            push_word    = {last_one, lowest_idx};
            pending_next = pending_reg & ~(N_CH'(1) << lowest_idx);
            if (last_one) state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  sparse_fifo #(
    .WIDTH(WORD_W),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_data(push_word),
    .pop      (pop),
    .pop_data (pop_word),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // ---------------- serializer ----------------
  logic [WORD_W-1:0] word_reg;
  logic              loaded_reg;
  logic [BEAT_W-1:0] beat_reg;
  logic [PAD_W-1:0]  padded;
  logic [LINK_W-1:0] beat_mux [BEATS];
  logic              beat_done;
  logic              word_done;

  assign beat_done = loaded_reg && out_ready;
  assign word_done = beat_done && (beat_reg == LAST_BEAT);
  // Load when idle, or in the same cycle the final beat leaves (no bubble).
  assign pop       = !fifo_empty && (!loaded_reg || word_done);

  assign padded = PAD_W'(word_reg);

  for (genvar gi = 0; gi < BEATS; gi++) begin : g_beat
    assign beat_mux[gi] = padded[gi*LINK_W +: LINK_W];
  end

  assign out_data  = beat_mux[beat_reg];
  assign out_valid = loaded_reg;
  assign busy      = (state_reg == SCAN) || !fifo_empty || loaded_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_reg   <= '0;
      loaded_reg <= 1'b0;
      beat_reg   <= '0;
    end else if (pop) begin
      word_reg   <= pop_word;
      loaded_reg <= 1'b1;
      beat_reg   <= '0;
    end else if (word_done) begin
      loaded_reg <= 1'b0;
      beat_reg   <= '0;
    end else if (beat_done) begin
      beat_reg <= beat_reg + 1'b1;
    end
  end

endmodule

// File: tb/tb_sparse_event_serializer.sv
module tb_sparse_event_serializer;

  logic        clk;
  logic        rst;
  logic [15:0] in_events;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        busy;

  int pass_cnt;
  int total_cnt;
  logic [3:0] got_q[$];

  sparse_event_serializer #(
    .N_CH  (16),
    .LINK_W(4),
    .DEPTH (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_events(in_events),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past the next rising edge; inputs are driven and outputs sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one frame: present it, take the edge, drop in_valid.
  task automatic send_frame(input logic [15:0] f);
    in_events = f;
    in_valid  = 1'b1;
    tick();
    in_valid  = 1'b0;
  endtask

  // Capture n accepted beats into got_q. Reports beats that changed while
  // stalled and idle cycles between beats while out_ready was high.
  task automatic collect(input int n, input bit rnd, output int stall_bad, output int bubbles);
    int cyc;
    logic held;
    logic [3:0] hd;
    got_q.delete();
    stall_bad = 0;
    bubbles   = 0;
    cyc       = 0;
    while (got_q.size() < n && cyc < 400) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_valid && out_ready) got_q.push_back(out_data);
      else if (got_q.size() > 0 && !out_valid && out_ready) bubbles++;
      held = out_valid && !out_ready;
      hd   = out_data;
      tick();
      if (held && (out_valid !== 1'b1 || out_data !== hd)) stall_bad++;
      cyc++;
    end
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready);
    else pass_cnt++;
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid);
    else pass_cnt++;
    total_cnt++;
    if (out_data !== 4'h0) $display("FAIL reset_out_data got %h want 0", out_data);
    else pass_cnt++;
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy);
    else pass_cnt++;
    $display("reset: in_ready=%b out_valid=%b out_data=%h busy=%b", in_ready, out_valid, out_data, busy);
  endtask

  task automatic test_two_events();
    logic [3:0] exp_b [4];
    int sb, bb;
    exp_b = '{4'h0, 4'h0, 4'h2, 4'h2};
    out_ready = 1'b1;
    send_frame(16'h0005);           // E0
    total_cnt++;
    if (in_ready !== 1'b0) $display("FAIL f5_in_ready_scan got %b want 0", in_ready);
    else pass_cnt++;
    tick();                         // E1: first push
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL f5_latency_e1 got %b want 0", out_valid);
    else pass_cnt++;
    tick();                         // E2: word loaded
    total_cnt++;
    if (out_valid !== 1'b1) $display("FAIL f5_latency_e2 got %b want 1", out_valid);
    else pass_cnt++;
    collect(4, 1'b0, sb, bb);
    for (int i = 0; i < 4; i++) begin
      total_cnt++;
      if (i >= got_q.size() || got_q[i] !== exp_b[i])
        $display("FAIL f5_beat%0d got %h want %h", i, (i < got_q.size()) ? got_q[i] : 4'hx, exp_b[i]);
      else pass_cnt++;
    end
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL f5_busy_end got %b want 0", busy);
    else pass_cnt++;
    $display("frame 0x0005: %0d beats, busy=%b", got_q.size(), busy);
  endtask

  task automatic test_full_stall();
    int sb, bb;
    logic [5:0] w;
    logic [5:0] exp_w;
    out_ready = 1'b0;
    send_frame(16'hFFFF);
    for (int i = 0; i < 10; i++) tick();
    total_cnt++;
    if (in_ready !== 1'b0) $display("FAIL ffff_stall_in_ready got %b want 0", in_ready);
    else pass_cnt++;
    total_cnt++;
    if (out_valid !== 1'b1 || out_data !== 4'h0)
      $display("FAIL ffff_stall_head got v=%b d=%h want v=1 d=0", out_valid, out_data);
    else pass_cnt++;
    total_cnt++;
    if (busy !== 1'b1) $display("FAIL ffff_stall_busy got %b want 1", busy);
    else pass_cnt++;
    collect(32, 1'b0, sb, bb);
    for (int i = 0; i < 16; i++) begin
      exp_w = {(i == 15), 5'(i)};
      w = (2 * i + 1 < got_q.size()) ? {got_q[2*i+1][1:0], got_q[2*i]} : 6'hxx;
      total_cnt++;
      if (w !== exp_w) $display("FAIL ffff_word%0d got %h want %h", i, w, exp_w);
      else pass_cnt++;
    end
    total_cnt++;
    if (in_ready !== 1'b1 || busy !== 1'b0)
      $display("FAIL ffff_end got in_ready=%b busy=%b want 1 0", in_ready, busy);
    else pass_cnt++;
    $display("frame 0xFFFF: %0d beats after release", got_q.size());
  endtask

  task automatic test_random_ready();
    logic [3:0] exp_b [4];
    int sb, bb;
    exp_b = '{4'h0, 4'h0, 4'hF, 4'h2};
    send_frame(16'h8001);
    collect(4, 1'b1, sb, bb);
    for (int i = 0; i < 4; i++) begin
      total_cnt++;
      if (i >= got_q.size() || got_q[i] !== exp_b[i])
        $display("FAIL f8001_beat%0d got %h want %h", i, (i < got_q.size()) ? got_q[i] : 4'hx, exp_b[i]);
      else pass_cnt++;
    end
    total_cnt++;
    if (sb !== 0) $display("FAIL f8001_stall_stable got %0d changes want 0", sb);
    else pass_cnt++;
    for (int i = 0; i < 3; i++) tick();
    $display("frame 0x8001 random ready: %0d beats, %0d stall changes", got_q.size(), sb);
  endtask

  task automatic test_empty_frame();
    int sb, bb;
    int saw_valid, saw_busy_ir;
    out_ready = 1'b1;
    send_frame(16'h0000);
`ifdef SPARSE_SER_EMPTY_FRAME_EN
    collect(2, 1'b0, sb, bb);
    total_cnt++;
    if (got_q.size() != 2 || got_q[0] !== 4'hF || got_q[1] !== 4'h3)
      $display("FAIL empty_frame_beats got n=%0d want F,3", got_q.size());
    else pass_cnt++;
    $display("frame 0x0000 (delimiter on): %0d beats", got_q.size());
`else
    saw_valid   = 0;
    saw_busy_ir = 0;
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL empty_in_ready_after_accept got %b want 1", in_ready);
    else pass_cnt++;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) saw_valid++;
      if (!in_ready) saw_busy_ir++;
      tick();
    end
    total_cnt++;
    if (saw_valid != 0) $display("FAIL empty_no_valid got %0d valid cycles want 0", saw_valid);
    else pass_cnt++;
    total_cnt++;
    if (saw_busy_ir != 0) $display("FAIL empty_in_ready_held got %0d low cycles want 0", saw_busy_ir);
    else pass_cnt++;
    $display("frame 0x0000 (delimiter off): %0d valid cycles", saw_valid);
`endif
  endtask

  task automatic test_reset_mid();
    int sb, bb;
    int extra;
    out_ready = 1'b1;
    send_frame(16'h00F0);
    for (int i = 0; i < 3; i++) tick();   // first word on the link
    #2 rst = 1'b1;                         // away from any edge
    #1;
    total_cnt++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 4'h0 || busy !== 1'b0)
      $display("FAIL midrst_outputs got ir=%b v=%b d=%h busy=%b want 1 0 0 0",
               in_ready, out_valid, out_data, busy);
    else pass_cnt++;
    tick();
    rst = 1'b0;
    tick();
    send_frame(16'h0002);
    collect(2, 1'b0, sb, bb);
    total_cnt++;
    if (got_q.size() != 2 || got_q[0] !== 4'h1 || got_q[1] !== 4'h2)
      $display("FAIL midrst_next_frame got n=%0d want beats 1,2", got_q.size());
    else pass_cnt++;
    extra = 0;
    for (int i = 0; i < 6; i++) begin
      if (out_valid) extra++;
      tick();
    end
    total_cnt++;
    if (extra != 0) $display("FAIL midrst_leftover got %0d valid cycles want 0", extra);
    else pass_cnt++;
    $display("reset mid-frame: next frame gave %0d beats, %0d leftover", got_q.size(), extra);
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_b [4];
    int sb, bb;
    exp_b = '{4'h0, 4'h2, 4'h1, 4'h2};
    out_ready = 1'b1;
    in_events = 16'h0001;
    in_valid  = 1'b1;
    tick();                                 // E0: frame 1 accepted
    total_cnt++;
    if (in_ready !== 1'b0) $display("FAIL b2b_scan1 got %b want 0", in_ready);
    else pass_cnt++;
    tick();                                 // E1: push, back to IDLE
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL b2b_ready_return got %b want 1", in_ready);
    else pass_cnt++;
    in_events = 16'h0002;
    tick();                                 // E2: frame 2 accepted
    in_valid = 1'b0;
    total_cnt++;
    if (in_ready !== 1'b0) $display("FAIL b2b_second_accept got %b want 0", in_ready);
    else pass_cnt++;
    collect(4, 1'b0, sb, bb);
    for (int i = 0; i < 4; i++) begin
      total_cnt++;
      if (i >= got_q.size() || got_q[i] !== exp_b[i])
        $display("FAIL b2b_beat%0d got %h want %h", i, (i < got_q.size()) ? got_q[i] : 4'hx, exp_b[i]);
      else pass_cnt++;
    end
    total_cnt++;
    if (bb != 0) $display("FAIL b2b_contiguous got %0d bubbles want 0", bb);
    else pass_cnt++;
    $display("back-to-back: %0d beats, %0d bubbles", got_q.size(), bb);
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    rst       = 1'b1;
    in_events = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #2;
    test_reset();
    tick();
    tick();
    rst = 1'b0;
    tick();
    test_two_events();
    tick();
    test_full_stall();
    tick();
    test_random_ready();
    test_empty_frame();
    tick();
    test_reset_mid();
    tick();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
